// File: rtl/knn_point_fetch_pkg.sv
// Shared point-format and FSM definitions for the KNN point fetcher and cores.
package knn_point_fetch_pkg;

  // Each point occupies two 32-bit words: {y,x} then label.
  localparam int PT_STRIDE = 8;
  localparam int WORD0_OFF = 0;
  localparam int WORD1_OFF = 4;
  localparam int WORD_STEP = WORD1_OFF - WORD0_OFF;

  // Default point format, shared with the KNN core array.
  localparam int COORD_W_DEF = 16;
  localparam int LABEL_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD0  = 3'd1,
    ST_RD1  = 3'd2,
    ST_PUSH = 3'd3,
    ST_FIN  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/knn_point_reg.sv
// Output holding register for one point with a valid/ready handshake.
module knn_point_reg #(
  parameter int COORD_W = 16,
  parameter int LABEL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic [LABEL_W-1:0] label_in,
  input  logic               last_in,
  input  logic               dp_ready,
  output logic               dp_valid,
  output logic [COORD_W-1:0] dp_x,
  output logic [COORD_W-1:0] dp_y,
  output logic [LABEL_W-1:0] dp_label,
  output logic               dp_last
);

  // Capture a point on load; hold it until the consumer accepts it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dp_valid <= 1'b0;
      dp_x     <= '0;
      dp_y     <= '0;
      dp_label <= '0;
      dp_last  <= 1'b0;
    end else if (load) begin
      dp_valid <= 1'b1;
      dp_x     <= x_in;
      dp_y     <= y_in;
      dp_label <= label_in;
      dp_last  <= last_in;
    end else if (dp_valid && dp_ready) begin
      dp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/knn_point_fetch.sv
// Native-bus read master that walks the training set and streams points to the KNN cores.
module knn_point_fetch
  import knn_point_fetch_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16,
  parameter int COORD_W = COORD_W_DEF,
  parameter int LABEL_W = LABEL_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    npoints,
  output logic                busy,
  output logic                done,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic                dp_valid,
  input  logic                dp_ready,
  output logic [COORD_W-1:0]  dp_x,
  output logic [COORD_W-1:0]  dp_y,
  output logic [LABEL_W-1:0]  dp_label,
  output logic                dp_last
);

  fetch_state_t       state;
  logic [ADDR_W-1:0]  addr;
  logic [CNT_W-1:0]   remaining;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic               rd_ack;
  logic               pt_load;

  // Read-only master: write channel is permanently idle.
  assign m_wdata = '0;
  assign m_wstrb = '0;

  // The address register only moves on a completed read, so it is the request address.
  assign m_addr  = addr;
  assign rd_ack  = m_valid && m_ready;
  assign pt_load = (state == ST_RD1) && rd_ack;

  // Run control: fetch word0, fetch word1, hand the point off, repeat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      x_q       <= '0;
      y_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      m_valid   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (npoints != '0) begin
              // Low address bits are forced to a word boundary.
              addr      <= base_addr & ~ADDR_W'(3);
              remaining <= npoints;
              m_valid   <= 1'b1;
              state     <= ST_RD0;
            end else begin
              done  <= 1'b1;
              state <= ST_FIN;
            end
          end
        end
        ST_RD0: begin
          if (rd_ack) begin
            x_q   <= m_rdata[COORD_W-1:0];
            y_q   <= m_rdata[2*COORD_W-1:COORD_W];
            addr  <= addr + ADDR_W'(WORD_STEP);
            state <= ST_RD1;
          end
        end
        ST_RD1: begin
          if (rd_ack) begin
            addr    <= addr + ADDR_W'(WORD_STEP);
            m_valid <= 1'b0;
            state   <= ST_PUSH;
          end
        end
        ST_PUSH: begin
          if (dp_ready) begin
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              done  <= 1'b1;
              state <= ST_FIN;
            end else begin
              m_valid <= 1'b1;
              state   <= ST_RD0;
            end
          end
        end
        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  knn_point_reg #(
    .COORD_W (COORD_W),
    .LABEL_W (LABEL_W)
  ) u_point_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (pt_load),
    .x_in     (x_q),
    .y_in     (y_q),
    .label_in (m_rdata[LABEL_W-1:0]),
    .last_in  (remaining == CNT_W'(1)),
    .dp_ready (dp_ready),
    .dp_valid (dp_valid),
    .dp_x     (dp_x),
    .dp_y     (dp_y),
    .dp_label (dp_label),
    .dp_last  (dp_last)
  );

endmodule

// File: tb/tb_knn_point_fetch.sv
// Directed bench for knn_point_fetch: memory model, read/point scoreboards, stability monitors.
module tb_knn_point_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] npoints;
  logic        busy, done;
  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        dp_valid;
  logic        dp_ready;
  logic [15:0] dp_x, dp_y;
  logic [7:0]  dp_label;
  logic        dp_last;

  always #5 clk = ~clk;

  knn_point_fetch dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .npoints(npoints),
    .busy(busy), .done(done), .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready), .dp_valid(dp_valid),
    .dp_ready(dp_ready), .dp_x(dp_x), .dp_y(dp_y), .dp_label(dp_label), .dp_last(dp_last)
  );

  // Memory model: word array with a programmable number of wait cycles per read
  logic [31:0] mem [0:4095];
  logic [3:0]  mem_wait;
  logic [3:0]  wcnt;

  always @(posedge clk) begin
    if (!m_valid || m_ready) wcnt <= '0;
    else                     wcnt <= wcnt + 4'd1;
  end
  assign m_ready = m_valid && (wcnt >= mem_wait);
  assign m_rdata = mem[m_addr[13:2]];

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  l;
    logic        last;
  } pt_t;

  pt_t         exp_pts [$];
  logic [31:0] exp_addr [$];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_beat_cyc = -1;
  int mv_cycles = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Places point i of a region in memory; optionally expects it on the stream.
  task automatic add_point(input logic [31:0] base, input int i, input logic [15:0] x,
                           input logic [15:0] y, input logic [7:0] l, input bit last,
                           input bit expect_it);
    logic [31:0] a;
    pt_t p;
    a = base + 32'(8 * i);
    mem[a[13:2]] = {y, x};
    mem[a[13:2] + 12'd1] = {24'hABCDE0, l};
    if (expect_it) begin
      p.x = x; p.y = y; p.l = l; p.last = last;
      exp_pts.push_back(p);
      exp_addr.push_back(a);
      exp_addr.push_back(a + 32'd4);
    end
  endtask

  // Monitor: scoreboard pops, handshake stability, and bus/stream exclusivity
  bit          m_pend = 0;
  logic [31:0] m_pend_addr;
  bit          dp_pend = 0;
  pt_t         dp_hold;
  always @(posedge clk) begin
    pt_t p;
    logic [31:0] a;
    if (rst) begin
      if (m_valid && m_ready) begin
        if (exp_addr.size() == 0) check("extra_read", {32'h0, m_addr}, 64'h1_0000_0000);
        else begin
          a = exp_addr.pop_front();
          check("rd_addr", {32'h0, m_addr}, {32'h0, a});
        end
      end
      if (dp_valid && dp_ready) begin
        if (exp_pts.size() == 0) check("extra_point", 64'(dp_x), 64'h1_0000);
        else begin
          p = exp_pts.pop_front();
          check("dp_x", 64'(dp_x), 64'(p.x));
          check("dp_y", 64'(dp_y), 64'(p.y));
          check("dp_label", 64'(dp_label), 64'(p.l));
          check("dp_last", 64'(dp_last), 64'(p.last));
        end
        if (dp_last) last_beat_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (m_valid) mv_cycles++;
      if (m_pend) begin
        check("m_valid_held", 64'(m_valid), 64'd1);
        check("m_addr_held", 64'(m_addr), 64'(m_pend_addr));
      end
      if (dp_pend) check("dp_held", {dp_valid, dp_last, dp_label, dp_y, dp_x},
                         {1'b1, dp_hold.last, dp_hold.l, dp_hold.y, dp_hold.x});
      if (dp_valid) check("no_fetch_while_push", 64'(m_valid), 64'd0);
    end
    m_pend      = rst && m_valid && !m_ready;
    m_pend_addr = m_addr;
    dp_pend     = rst && dp_valid && !dp_ready;
    dp_hold.x = dp_x; dp_hold.y = dp_y; dp_hold.l = dp_label; dp_hold.last = dp_last;
    cyc++;
  end

  task automatic pulse_start(input logic [31:0] b, input logic [15:0] n);
    base_addr = b;
    npoints   = n;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 400) begin @(posedge clk); #1; k++; end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
    @(posedge clk); #1;
    check({tag, "_done_1cyc"}, 64'(done), 64'd0);
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
    check({tag, "_pts_left"}, 64'(exp_pts.size()), 64'd0);
    check({tag, "_rds_left"}, 64'(exp_addr.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, k, dc, mv;
    for (int i = 0; i < 4096; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    rst = 1'b0; start = 1'b0; base_addr = '0; npoints = '0; dp_ready = 1'b1; mem_wait = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_outs", {busy, done, m_valid, dp_valid, dp_last}, 5'b0);
    check("rst_addr", 64'(m_addr), 64'd0);
    check("rst_point", {dp_x, dp_y, dp_label}, 40'd0);
    check("wr_tied", {m_wdata, m_wstrb}, 36'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: zero-wait, three points, last point at coordinate extreme
    add_point(32'h1000, 0, 16'd1, 16'd2, 8'd5, 1'b0, 1'b1);
    add_point(32'h1000, 1, 16'd3, 16'd4, 8'd6, 1'b0, 1'b1);
    add_point(32'h1000, 2, 16'hFFFF, 16'd0, 8'd7, 1'b1, 1'b1);
    pulse_start(32'h1000, 16'd3);
    check("t1_busy", 64'(busy), 64'd1);
    // Start cycle, RD0, RD1 -> point visible two edges after start is sampled
    lat = 0;
    while (!dp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("t1_latency", 64'(lat), 64'd2);
    wait_done("t1");
    check("t1_done_after_last", 64'(done_cyc - last_beat_cyc), 64'd1);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);

    // 2: empty run, no bus traffic, one-cycle busy and done
    mv = mv_cycles; dc = done_cnt;
    check("t2_idle_busy", 64'(busy), 64'd0);
    pulse_start(32'h1000, 16'd0);
    check("t2_busy", 64'(busy), 64'd1);
    check("t2_done", 64'(done), 64'd1);
    @(posedge clk); #1;
    check("t2_busy_off", 64'(busy), 64'd0);
    check("t2_done_off", 64'(done), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t2_no_reads", 64'(mv_cycles), 64'(mv));
    check("t2_done_cnt", 64'(done_cnt), 64'(dc + 1));

    // 3: four wait cycles per read
    mem_wait = 4'd4;
    add_point(32'h1000, 0, 16'd10, 16'd20, 8'h11, 1'b0, 1'b1);
    add_point(32'h1000, 1, 16'd30, 16'd40, 8'h22, 1'b1, 1'b1);
    pulse_start(32'h1000, 16'd2);
    wait_done("t3");

    // 4: consumer stalls on point 0 for ten cycles
    mem_wait = 4'd0;
    dp_ready = 1'b0;
    add_point(32'h1000, 0, 16'd100, 16'd200, 8'h33, 1'b0, 1'b1);
    add_point(32'h1000, 1, 16'd300, 16'd400, 8'h44, 1'b1, 1'b1);
    pulse_start(32'h1000, 16'd2);
    k = 0;
    while (!dp_valid && k < 50) begin @(posedge clk); #1; k++; end
    check("t4_dp_valid", 64'(dp_valid), 64'd1);
    mv = mv_cycles;
    repeat (10) @(posedge clk);
    #1;
    check("t4_still_valid", 64'(dp_valid), 64'd1);
    check("t4_no_fetch", 64'(mv_cycles), 64'(mv));
    dp_ready = 1'b1;
    wait_done("t4");

    // 5: second start mid-run is ignored
    mem_wait = 4'd2;
    for (int i = 0; i < 5; i++) add_point(32'h2000, i, 16'hBAD0, 16'hBAD1, 8'hEE, 1'b0, 1'b0);
    add_point(32'h1000, 0, 16'd7, 16'd8, 8'h01, 1'b0, 1'b1);
    add_point(32'h1000, 1, 16'd9, 16'd10, 8'h02, 1'b0, 1'b1);
    add_point(32'h1000, 2, 16'd11, 16'd12, 8'h03, 1'b1, 1'b1);
    dc = done_cnt;
    pulse_start(32'h1000, 16'd3);
    repeat (4) @(posedge clk);
    #1;
    pulse_start(32'h2000, 16'd5);
    wait_done("t5");
    repeat (5) @(posedge clk);
    #1;
    check("t5_done_cnt", 64'(done_cnt), 64'(dc + 1));
    check("t5_idle", {busy, m_valid}, 2'b0);

    // 6: reset during RD1 of point 1, then a fresh run from a new base
    mem_wait = 4'd3;
    add_point(32'h1000, 0, 16'd21, 16'd22, 8'h0A, 1'b0, 1'b1);
    add_point(32'h1000, 1, 16'd23, 16'd24, 8'h0B, 1'b0, 1'b1);
    add_point(32'h1000, 2, 16'd25, 16'd26, 8'h0C, 1'b1, 1'b1);
    dc = done_cnt;
    pulse_start(32'h1000, 16'd3);
    k = 0;
    while (!(m_valid && m_addr == 32'h100C) && k < 100) begin @(posedge clk); #1; k++; end
    check("t6_in_rd1", {m_valid, m_addr}, {1'b1, 32'h100C});
    check("t6_pts_pending", 64'(exp_pts.size()), 64'd2);
    rst = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_drop", {m_valid, dp_valid, busy}, 3'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_pts.delete();
    exp_addr.delete();
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_done", 64'(done_cnt), 64'(dc));
    check("t6_quiet", {m_valid, dp_valid}, 2'b0);
    mem_wait = 4'd0;
    add_point(32'h3000, 0, 16'd51, 16'd52, 8'h5A, 1'b0, 1'b1);
    add_point(32'h3000, 1, 16'd53, 16'd54, 8'h5B, 1'b1, 1'b1);
    pulse_start(32'h3000, 16'd2);
    check("t6_first_addr", {m_valid, m_addr}, {1'b1, 32'h3000});
    wait_done("t6");
    check("t6_done_cnt", 64'(done_cnt), 64'(dc + 1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/knn_point_fetch.md
Name: knn_point_fetch

Overview:
- Native-bus initiator that reads the training set (data points plus labels) from system memory.
- Streams the points, one per handshake, to the bank of KNN cores.
- Is the master-side counterpart of the KNN peripheral's slave register interface. The CPU programs the base address and point count; the block then walks memory autonomously.
- Sits between the memory interconnect and the data-point input of the KNN core array.

Parameters:
- ADDR_W, 32, native-bus byte-address width
- DATA_W, 32, native-bus data width
- CNT_W, 16, width of the point counter (max points = 2^CNT_W-1)
- COORD_W, 16, width of one coordinate (x or y)
- LABEL_W, 8, label width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (rst=0 resets on the rising clk edge)
- start  in  1  one-cycle pulse; begins a fetch run; ignored while busy
- base_addr  in  ADDR_W  byte address of point 0; sampled on start
- npoints  in  CNT_W  number of points; sampled on start
- busy  out  1  run in progress
- done  out  1  one-cycle pulse when the last point has been accepted downstream
- m_valid  out  1  native-master request valid
- m_addr  out  ADDR_W  request address (word aligned)
- m_wdata  out  DATA_W  tied 0 (read-only master)
- m_wstrb  out  DATA_W/8  tied 0
- m_rdata  in  DATA_W  read data, valid in the cycle m_ready=1
- m_ready  in  1  request completed
- dp_valid  out  1  point available
- dp_ready  in  1  consumer accepts point
- dp_x  out  COORD_W  x coordinate
- dp_y  out  COORD_W  y coordinate
- dp_label  out  LABEL_W  label
- dp_last  out  1  marks the final point of the run

Behaviour:
- Memory layout per point: 2 words, 8 bytes.
  - word0 = {y, x}, with x in [COORD_W-1:0].
  - word1[LABEL_W-1:0] = label; the upper bits are ignored.
  - Point i is at base_addr + 8*i.
- Reset values: all outputs 0, FSM=IDLE, counters 0.
- Native handshake rules:
  - m_valid/m_addr are held stable until the cycle m_ready=1.
  - m_rdata is captured in that cycle.
  - m_valid drops in the following cycle unless the next request is issued immediately.
  - m_ready while m_valid=0 is ignored.
- FSM states: IDLE, RD0, RD1, PUSH, FIN.
  - IDLE: on start with npoints!=0 → RD0; busy=1; address register = base_addr; remaining = npoints.
  - IDLE: on start with npoints==0 → FIN directly. No bus access; done still pulses.
  - RD0: m_valid=1, m_addr=addr. On m_ready, latch x,y; addr+=4 → RD1.
  - RD1: m_valid=1, m_addr=addr. On m_ready, latch label; addr+=4 → PUSH.
  - PUSH: dp_valid=1, with data held stable until dp_ready. dp_last=1 when remaining==1. On dp_ready: remaining-=1; → FIN if remaining was 1, else → RD0.
  - FIN: done=1 for exactly one cycle; busy=0 → IDLE.
- Latency:
  - Minimum with zero-wait memory: point 0 visible on dp_* 3 cycles after start (RD0, RD1, PUSH).
  - Minimum steady-state throughput: one point per 3 cycles.
  - No prefetch overlap.
- Address arithmetic is modulo 2^ADDR_W; wrap past the top of the address space is silent.
- start while busy: ignored; the run continues unchanged; base_addr/npoints are not resampled.
- dp_ready asserted outside PUSH: ignored.
- rst=0 mid-run: m_valid and dp_valid drop in the next cycle; any outstanding bus read is abandoned; no done pulse.

Decomposition:
- Shared header iob_knn.vh holds:
  - point stride (8) and word offsets (0, 4)
  - FSM state encodings
  - default COORD_W/LABEL_W, so knn_point_fetch and the KNN core agree on point format
- One natural sub-module: knn_point_reg. It is the output holding register with the dp_valid/dp_ready handshake, capturing x,y,label,last.
- Everything else stays in the top FSM.

Test Plan:
- Zero-wait memory, base=0x1000, npoints=3, points (1,2,L5),(3,4,L6),(0xFFFF,0,L7), dp_ready=1:
  - reads at 0x1000,0x1004,0x1008,…,0x1014
  - three dp beats in order; dp_last only on the third
  - done pulse 1 cycle after the third beat; busy low after it
- npoints=0, start:
  - no m_valid ever
  - done pulses once, 1 cycle after start
  - busy high for exactly 1 cycle
- Memory with m_ready delayed 4 cycles per read:
  - m_addr/m_valid stable throughout each wait
  - data correct; 2 points delivered
- dp_ready held 0 for 10 cycles on point 0:
  - dp_* stable
  - no new m_valid issued until acceptance
- start pulsed again mid-run with base=0x2000:
  - ignored; all addresses stay in the original 0x1000 region
- rst=0 asserted during RD1 of point 1, then released and a new run started:
  - m_valid/dp_valid 0 after the next edge
  - the new run restarts cleanly from the new base_addr
